// File: rtl/ei_tdp_ram_pkg.sv
// Shared types and latency selection for the true dual-port RAM.
// EI_TDP_RAM_OUT_REG_EN adds an output register per port (read latency 2).
package ei_tdp_ram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    typedef enum logic {READ_FIRST, WRITE_FIRST} rd_mode_e;

`ifdef EI_TDP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    function automatic rd_mode_e rd_mode(input bit wr_first);
        return wr_first ? WRITE_FIRST : READ_FIRST;
    endfunction

endpackage

// File: rtl/ei_tdp_ram_port_out.sv
// Per-port read-data pipeline: latency-1 register plus an optional second stage
// enabled by EI_TDP_RAM_OUT_REG_EN (through ei_tdp_ram_pkg::LAT).
module ei_tdp_ram_port_out
    import ei_tdp_ram_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    logic [DATA_W-1:0] rdata1_q;
    logic              rvalid1_q;

    // rdata only moves on an access so it holds while the port is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata1_q  <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid1_q <= en_i;
            if (en_i) rdata1_q <= rdata_i;
        end
    end

    if (LAT > 1) begin : g_out_reg
        logic [DATA_W-1:0] rdata2_q;
        logic              rvalid2_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata2_q  <= '0;
                rvalid2_q <= 1'b0;
            end else begin
                rvalid2_q <= rvalid1_q;
                if (rvalid1_q) rdata2_q <= rdata1_q;
            end
        end

        assign rdata_o  = rdata2_q;
        assign rvalid_o = rvalid2_q;
    end else begin : g_direct
        assign rdata_o  = rdata1_q;
        assign rvalid_o = rvalid1_q;
    end

endmodule

// File: rtl/ei_tdp_ram_core.sv
// True dual-port synchronous RAM with A-priority write collisions and a saturating
// collision counter. EI_TDP_RAM_OUT_REG_EN selects read latency 2 instead of 1.
module ei_tdp_ram_core
    import ei_tdp_ram_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter bit WR_FIRST = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              wr_coll,
    output logic [CNT_W-1:0]  coll_cnt
);

    localparam rd_mode_e MODE = rd_mode(WR_FIRST);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              a_wr, b_wr, coll_d;
    logic [DATA_W-1:0] a_rdata_d, b_rdata_d;
    logic              wr_coll_q;
    logic [CNT_W-1:0]  coll_cnt_q;

    assign a_wr   = a_en & a_we;
    assign b_wr   = b_en & b_we;
    assign coll_d = a_wr & b_wr & (a_addr == b_addr);

    // array is read before this edge's writes land, so cross-port reads see old data
    assign a_rdata_d = (a_wr && MODE == WRITE_FIRST) ? a_wdata : mem[a_addr];
    assign b_rdata_d = (b_wr && MODE == WRITE_FIRST) ? b_wdata : mem[b_addr];

    always_ff @(posedge clk) begin
        if (a_wr) mem[a_addr] <= a_wdata;
        if (b_wr && !coll_d) mem[b_addr] <= b_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_coll_q  <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            wr_coll_q <= coll_d;
            if (coll_d && !(&coll_cnt_q)) coll_cnt_q <= coll_cnt_q + CNT_W'(1);
        end
    end

    assign wr_coll  = wr_coll_q;
    assign coll_cnt = coll_cnt_q;

    ei_tdp_ram_port_out #(.DATA_W(DATA_W)) u_out_a (
        .clk      (clk),
        .rst      (rst),
        .en_i     (a_en),
        .rdata_i  (a_rdata_d),
        .rdata_o  (a_rdata),
        .rvalid_o (a_rvalid)
    );

    ei_tdp_ram_port_out #(.DATA_W(DATA_W)) u_out_b (
        .clk      (clk),
        .rst      (rst),
        .en_i     (b_en),
        .rdata_i  (b_rdata_d),
        .rdata_o  (b_rdata),
        .rvalid_o (b_rvalid)
    );

endmodule

// File: tb/tb_ei_tdp_ram_core.sv
// Directed self-checking bench for ei_tdp_ram_core (CNT_W=2 so saturation is reachable).
module tb_ei_tdp_ram_core;

`ifdef EI_TDP_RAM_OUT_REG_EN
    localparam int TB_LAT = 2;
`else
    localparam int TB_LAT = 1;
`endif
    localparam bit TB_WR_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_we = 1'b0;
    logic [7:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic [31:0] a_rdata;
    logic        a_rvalid;
    logic        b_en = 1'b0, b_we = 1'b0;
    logic [7:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [31:0] b_rdata;
    logic        b_rvalid;
    logic        wr_coll;
    logic [1:0]  coll_cnt;

    int errors = 0;
    int checks = 0;

    ei_tdp_ram_core #(.ADDR_W(8), .DATA_W(32), .WR_FIRST(TB_WR_FIRST), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .wr_coll(wr_coll), .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0;
        b_en = 1'b0; b_we = 1'b0;
    endtask

    task automatic drv_a(input logic we, input logic [7:0] addr, input logic [31:0] wd);
        a_en = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic drv_b(input logic we, input logic [7:0] addr, input logic [31:0] wd);
        b_en = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic wait_lat();
        idle();
        repeat (TB_LAT - 1) tick();
    endtask

    task automatic test_reset();
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_a_rvalid got=%b exp=0", a_rvalid); end
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_b_rvalid got=%b exp=0", b_rvalid); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rst_a_rdata got=%h exp=0", a_rdata); end
        checks++; if (b_rdata !== 32'h0) begin errors++; $display("FAIL rst_b_rdata got=%h exp=0", b_rdata); end
        checks++; if (wr_coll !== 1'b0) begin errors++; $display("FAIL rst_wr_coll got=%b exp=0", wr_coll); end
        checks++; if (coll_cnt !== 2'd0) begin errors++; $display("FAIL rst_coll_cnt got=%0d exp=0", coll_cnt); end
    endtask

    task automatic test_basic();
        logic exp_v;
        drv_a(1'b1, 8'h00, 32'h1234_5678);
        tick();
        drv_a(1'b1, 8'h10, 32'hDEAD_BEEF);
        tick();
        wait_lat();
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL basic_a_write got=%b/%h exp=1/deadbeef", a_rvalid, a_rdata); end
        tick();
        drv_b(1'b0, 8'h10, 32'h0);
        tick();
        exp_v = (TB_LAT == 1);
        checks++; if (b_rvalid !== exp_v) begin
            errors++; $display("FAIL latency_first_edge got=%b exp=%b", b_rvalid, exp_v); end
        wait_lat();
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL basic_b_read got=%b/%h exp=1/deadbeef", b_rvalid, b_rdata); end
        tick();
        checks++; if (b_rvalid !== 1'b0 || b_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL idle_hold got=%b/%h exp=0/deadbeef", b_rvalid, b_rdata); end
    endtask

    task automatic test_write_coll();
        drv_a(1'b1, 8'h20, 32'h1111_1111);
        drv_b(1'b1, 8'h20, 32'h2222_2222);
        tick();
        checks++; if (wr_coll !== 1'b1 || coll_cnt !== 2'd1) begin
            errors++; $display("FAIL coll_pulse got=%b/%0d exp=1/1", wr_coll, coll_cnt); end
        wait_lat();
        checks++; if (a_rdata !== 32'h1111_1111 || b_rdata !== 32'h2222_2222) begin
            errors++; $display("FAIL coll_rdata got=%h/%h exp=11111111/22222222", a_rdata, b_rdata); end
        tick();
        checks++; if (wr_coll !== 1'b0 || coll_cnt !== 2'd1) begin
            errors++; $display("FAIL coll_one_cycle got=%b/%0d exp=0/1", wr_coll, coll_cnt); end
        drv_b(1'b0, 8'h20, 32'h0);
        tick();
        wait_lat();
        checks++; if (b_rdata !== 32'h1111_1111) begin
            errors++; $display("FAIL coll_a_priority got=%h exp=11111111", b_rdata); end
    endtask

    task automatic test_cross_rw();
        logic [31:0] exp_a;
        drv_b(1'b1, 8'h30, 32'hAAAA_0000);
        drv_a(1'b1, 8'h31, 32'h0000_0001);
        tick();
        drv_a(1'b1, 8'h30, 32'h5555_FFFF);
        drv_b(1'b0, 8'h30, 32'h0);
        tick();
        wait_lat();
        exp_a = TB_WR_FIRST ? 32'h5555_FFFF : 32'hAAAA_0000;
        checks++; if (b_rdata !== 32'hAAAA_0000) begin
            errors++; $display("FAIL cross_b_old got=%h exp=aaaa0000", b_rdata); end
        checks++; if (a_rdata !== exp_a) begin
            errors++; $display("FAIL cross_a_wrmode got=%h exp=%h", a_rdata, exp_a); end
        drv_b(1'b1, 8'h31, 32'h0000_0002);
        drv_a(1'b0, 8'h31, 32'h0);
        tick();
        wait_lat();
        checks++; if (a_rdata !== 32'h0000_0001 || b_rdata !== 32'h0000_0002) begin
            errors++; $display("FAIL cross_swap got=%h/%h exp=00000001/00000002", a_rdata, b_rdata); end
        drv_a(1'b0, 8'h30, 32'h0);
        tick();
        wait_lat();
        checks++; if (a_rdata !== 32'h5555_FFFF) begin
            errors++; $display("FAIL cross_stored got=%h exp=5555ffff", a_rdata); end
    endtask

    task automatic test_wrap();
        logic        rv [4];
        logic [31:0] rd [4];
        drv_a(1'b1, 8'hFF, 32'h0000_0001);
        tick();
        idle();
        tick();
        tick();
        drv_a(1'b0, 8'hFF, 32'h0);
        tick();
        rv[0] = a_rvalid; rd[0] = a_rdata;
        drv_a(1'b0, 8'hFF + 8'h01, 32'h0);
        tick();
        rv[1] = a_rvalid; rd[1] = a_rdata;
        idle();
        tick();
        rv[2] = a_rvalid; rd[2] = a_rdata;
        tick();
        rv[3] = a_rvalid; rd[3] = a_rdata;
        checks++; if (rv[TB_LAT-1] !== 1'b1 || rd[TB_LAT-1] !== 32'h0000_0001) begin
            errors++; $display("FAIL wrap_ff got=%b/%h exp=1/00000001", rv[TB_LAT-1], rd[TB_LAT-1]); end
        checks++; if (rv[TB_LAT] !== 1'b1 || rd[TB_LAT] !== 32'h1234_5678) begin
            errors++; $display("FAIL wrap_00 got=%b/%h exp=1/12345678", rv[TB_LAT], rd[TB_LAT]); end
        checks++; if (rv[TB_LAT+1] !== 1'b0) begin
            errors++; $display("FAIL wrap_end got=%b exp=0", rv[TB_LAT+1]); end
    endtask

    task automatic test_reset_mid();
        drv_a(1'b0, 8'h10, 32'h0);
        tick();
        idle();
        #1 rst = 1'b1;
        #1;
        checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0 || coll_cnt !== 2'd0) begin
            errors++; $display("FAIL rst_mid got=%b/%h/%0d exp=0/0/0", a_rvalid, a_rdata, coll_cnt); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
                errors++; $display("FAIL rst_no_rvalid cyc=%0d got=%b/%b exp=0/0", i, a_rvalid, b_rvalid); end
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_c;
        for (int i = 0; i < 5; i++) begin
            drv_a(1'b1, 8'h40 + 8'(i), 32'h0000_00A0);
            drv_b(1'b1, 8'h40 + 8'(i), 32'h0000_00B0);
            tick();
            exp_c = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++; if (wr_coll !== 1'b1 || coll_cnt !== exp_c) begin
                errors++; $display("FAIL sat_step%0d got=%b/%0d exp=1/%0d", i, wr_coll, coll_cnt, exp_c); end
        end
        drv_a(1'b0, 8'h20, 32'h0);
        drv_b(1'b0, 8'h20, 32'h0);
        tick();
        checks++; if (wr_coll !== 1'b0 || coll_cnt !== 2'd3) begin
            errors++; $display("FAIL both_read_no_coll got=%b/%0d exp=0/3", wr_coll, coll_cnt); end
        wait_lat();
        checks++; if (a_rdata !== 32'h1111_1111 || b_rdata !== 32'h1111_1111) begin
            errors++; $display("FAIL both_read_data got=%h/%h exp=11111111/11111111", a_rdata, b_rdata); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_write_coll();
        test_cross_rw();
        test_wrap();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
